// File: rtl/mul_arb_pkg.sv
// Shared types and the round-robin pick function for the multiplier-sharing arbiter.
package mul_arb_pkg;

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_NUM_REQ = 4;
  localparam int MAX_REQ     = 32;
  localparam int PICK_W      = 5;
  localparam int PICK_N_W    = 6;

  typedef struct packed {
    logic              found;
    logic [PICK_W-1:0] idx;
  } pick_t;

  // First set bit of valid, searching last+1, last+2, ... modulo n (n <= MAX_REQ).
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0]  valid,
                                    input logic [PICK_W-1:0]   last,
                                    input logic [PICK_N_W-1:0] n);
    pick_t               r;
    logic [PICK_N_W-1:0] cand;
    r    = '0;
    cand = '0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      cand = PICK_N_W'(last) + PICK_N_W'(k);
      if (cand >= n) cand = cand - n;
      if (!r.found && (PICK_N_W'(k) <= n) && valid[cand[PICK_W-1:0]]) begin
        r.found = 1'b1;
        r.idx   = cand[PICK_W-1:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/signed_mul_core.sv
// Purely combinational full-width signed multiplier.
module signed_mul_core #(
  parameter int DATA_W = 32
) (
  input  logic signed [DATA_W-1:0]   i_a,
  input  logic signed [DATA_W-1:0]   i_b,
  output logic signed [2*DATA_W-1:0] o_product
);

  assign o_product = i_a * i_b;

endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter sharing one signed multiplier among NUM_REQ valid/ready requesters,
// with a multicycle settle before the registered product is handed back.
module mul_share_arbiter
  import mul_arb_pkg::*;
#(
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int CALC_CYCLES = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*DATA_W-1:0]   req_a,
  input  logic [NUM_REQ*DATA_W-1:0]   req_b,
  output logic [NUM_REQ-1:0]          resp_valid,
  input  logic [NUM_REQ-1:0]          resp_ready,
  output logic [2*DATA_W-1:0]         resp_product,
  output logic                        busy,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = (CALC_CYCLES > 1) ? $clog2(CALC_CYCLES) : 1;

  state_t              r_state;
  state_t              w_next_state;
  logic [GW-1:0]       r_last_grant;
  logic [GW-1:0]       r_grant_id;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic [CW-1:0]       r_cnt;
  logic [2*DATA_W-1:0] r_product;
  logic [2*DATA_W-1:0] w_product;
  pick_t               w_pick;
  logic [GW-1:0]       w_pick_id;
  logic                w_unused_pick;
  logic                w_accept;
  logic                w_calc_done;
  logic                w_resp_take;

  assign w_pick        = rr_pick(MAX_REQ'(req_valid), PICK_W'(r_last_grant), PICK_N_W'(NUM_REQ));
  assign w_pick_id     = GW'(w_pick.idx);
  assign w_unused_pick = ^w_pick.idx;

  assign w_accept    = (r_state == IDLE) && w_pick.found;
  assign w_calc_done = (r_state == CALC) && (r_cnt == '0);
  assign w_resp_take = (r_state == RESP) && resp_ready[r_grant_id];

  signed_mul_core #(.DATA_W(DATA_W)) u_mul (
    .i_a       (r_a),
    .i_b       (r_b),
    .o_product (w_product)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept)    w_next_state = CALC;
      CALC:    if (w_calc_done) w_next_state = RESP;
      RESP:    if (w_resp_take) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    if (w_accept) req_ready[w_pick_id] = 1'b1;
    if (r_state == RESP) resp_valid[r_grant_id] = 1'b1;
    busy = (r_state != IDLE);
  end

  // Operands stay frozen from accept until capture so the multiplier path has CALC_CYCLES to settle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= GW'(NUM_REQ - 1);
      r_grant_id   <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_cnt        <= '0;
      r_product    <= '0;
    end else begin
      if (w_accept) begin
        r_a        <= req_a[w_pick_id*DATA_W +: DATA_W];
        r_b        <= req_b[w_pick_id*DATA_W +: DATA_W];
        r_grant_id <= w_pick_id;
        r_cnt      <= CW'(CALC_CYCLES - 1);
      end
      if (r_state == CALC) begin
        if (w_calc_done) r_product <= w_product;
        else             r_cnt     <= r_cnt - 1'b1;
      end
      if (w_resp_take) r_last_grant <= r_grant_id;
    end
  end

  assign resp_product = r_product;
  assign grant_id     = r_grant_id;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed self-checking bench for mul_share_arbiter (NUM_REQ=4, DATA_W=32, CALC_CYCLES=2).
module tb_mul_share_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 32;

  logic                      clk;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic [NUM_REQ-1:0]        resp_valid;
  logic [NUM_REQ-1:0]        resp_ready;
  logic [2*DATA_W-1:0]       resp_product;
  logic                      busy;
  logic [1:0]                grant_id;

  int checks = 0;
  int errors = 0;

  mul_share_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .CALC_CYCLES(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_product (resp_product),
    .busy         (busy),
    .grant_id     (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checks++;
      if (!$onehot0(req_ready) || !$onehot0(resp_valid)) begin
        errors++;
        $display("[TB] FAIL onehot0: req_ready=%b resp_valid=%b", req_ready, resp_valid);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int idx, input logic [31:0] a, input logic [31:0] b);
    req_a[idx*DATA_W +: DATA_W] = a;
    req_b[idx*DATA_W +: DATA_W] = b;
  endtask

  task automatic test_reset;
    rst_n      = 1'b0;
    req_valid  = '0;
    resp_ready = '1;
    req_a      = '0;
    req_b      = '0;
    repeat (2) tick;
    checks++; if (req_ready !== 4'b0) begin errors++; $display("[TB] FAIL reset_req_ready: got %b want 0000", req_ready); end
    checks++; if (resp_valid !== 4'b0) begin errors++; $display("[TB] FAIL reset_resp_valid: got %b want 0000", resp_valid); end
    checks++; if (resp_product !== 64'h0) begin errors++; $display("[TB] FAIL reset_product: got %h want 0", resp_product); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("[TB] FAIL reset_grant_id: got %0d want 0", grant_id); end
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_single;
    set_op(0, 32'd7, -32'sd3);
    req_valid = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL single_accept: got %b want 0001", req_ready); end
    tick;
    req_valid = '0;
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL single_busy: got %b want 1", busy); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("[TB] FAIL single_grant: got %0d want 0", grant_id); end
    checks++; if (resp_valid !== 4'b0) begin errors++; $display("[TB] FAIL single_early1: got %b want 0000", resp_valid); end
    tick;
    checks++; if (resp_valid !== 4'b0) begin errors++; $display("[TB] FAIL single_early2: got %b want 0000", resp_valid); end
    tick;
    checks++; if (resp_valid !== 4'b0001) begin errors++; $display("[TB] FAIL single_resp: got %b want 0001", resp_valid); end
    checks++; if (resp_product !== 64'hFFFF_FFFF_FFFF_FFEB) begin errors++; $display("[TB] FAIL single_product: got %h want ffffffffffffffeb", resp_product); end
    tick;
    checks++; if (resp_valid !== 4'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL single_done: got resp_valid=%b busy=%b want 0000/0", resp_valid, busy); end
  endtask

  task automatic test_corners;
    logic [31:0] ta [4];
    logic [31:0] tb [4];
    logic [63:0] tp [4];
    int n;
    ta[0] = 32'h8000_0000; tb[0] = 32'h8000_0000; tp[0] = 64'h4000_0000_0000_0000;
    ta[1] = 32'h8000_0000; tb[1] = 32'h0000_0001; tp[1] = 64'hFFFF_FFFF_8000_0000;
    ta[2] = 32'h7FFF_FFFF; tb[2] = 32'h7FFF_FFFF; tp[2] = 64'h3FFF_FFFF_0000_0001;
    ta[3] = 32'h0001_2345; tb[3] = 32'h0000_0000; tp[3] = 64'h0;
    for (int i = 0; i < 4; i++) begin
      set_op(0, ta[i], tb[i]);
      req_valid = 4'b0001;
      tick;
      req_valid = '0;
      n = 0;
      while (resp_valid === 4'b0 && n < 8) begin
        tick;
        n++;
      end
      checks++; if (n !== 2) begin errors++; $display("[TB] FAIL corner%0d_latency: got %0d cycles want 2", i, n); end
      checks++; if (resp_product !== tp[i]) begin errors++; $display("[TB] FAIL corner%0d_product: got %h want %h", i, resp_product, tp[i]); end
      tick;
    end
  endtask

  task automatic test_round_robin;
    int exp;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) set_op(i, 32'(i + 1), 32'd10);
    req_valid = 4'b1111;
    #1;
    for (int k = 0; k < 5; k++) begin
      exp = k % 4;
      checks++; if (req_ready !== 4'(1 << exp) || busy !== 1'b0) begin errors++; $display("[TB] FAIL rr%0d_accept: got req_ready=%b busy=%b want %b/0", k, req_ready, busy, 4'(1 << exp)); end
      tick;
      checks++; if (grant_id !== 2'(exp)) begin errors++; $display("[TB] FAIL rr%0d_grant: got %0d want %0d", k, grant_id, exp); end
      tick;
      tick;
      checks++; if (resp_valid !== 4'(1 << exp)) begin errors++; $display("[TB] FAIL rr%0d_resp: got %b want %b", k, resp_valid, 4'(1 << exp)); end
      checks++; if (resp_product !== 64'((exp + 1) * 10)) begin errors++; $display("[TB] FAIL rr%0d_product: got %h want %h", k, resp_product, 64'((exp + 1) * 10)); end
      tick;
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure;
    set_op(1, -32'sd5, 32'd6);
    req_valid  = 4'b0010;
    resp_ready = '0;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("[TB] FAIL bp_accept: got %b want 0010", req_ready); end
    tick;
    req_valid = 4'b1111;
    tick;
    tick;
    checks++; if (resp_valid !== 4'b0010) begin errors++; $display("[TB] FAIL bp_resp: got %b want 0010", resp_valid); end
    resp_ready = 4'b1101;
    for (int c = 0; c < 10; c++) begin
      tick;
      checks++;
      if (resp_valid !== 4'b0010 || resp_product !== 64'hFFFF_FFFF_FFFF_FFE2 || req_ready !== 4'b0 || busy !== 1'b1) begin
        errors++;
        $display("[TB] FAIL bp_hold%0d: got resp_valid=%b product=%h req_ready=%b busy=%b want 0010/ffffffffffffffe2/0000/1",
                 c, resp_valid, resp_product, req_ready, busy);
      end
    end
    resp_ready = '1;
    tick;
    #1;
    checks++; if (req_ready !== 4'b0100 || busy !== 1'b0) begin errors++; $display("[TB] FAIL bp_next_grant: got req_ready=%b busy=%b want 0100/0", req_ready, busy); end
    req_valid = '0;
  endtask

  task automatic test_reset_in_calc;
    set_op(2, 32'd9, 32'd9);
    req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("[TB] FAIL rst_pre_accept: got %b want 0100", req_ready); end
    tick;
    req_valid = '0;
    checks++; if (grant_id !== 2'd2 || busy !== 1'b1) begin errors++; $display("[TB] FAIL rst_pre_state: got grant=%0d busy=%b want 2/1", grant_id, busy); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || grant_id !== 2'd0 || resp_valid !== 4'b0 || resp_product !== 64'h0 || req_ready !== 4'b0) begin
      errors++;
      $display("[TB] FAIL rst_abort: got busy=%b grant=%0d resp_valid=%b product=%h req_ready=%b want all 0",
               busy, grant_id, resp_valid, resp_product, req_ready);
    end
    for (int c = 0; c < 3; c++) begin
      tick;
      checks++; if (resp_valid !== 4'b0) begin errors++; $display("[TB] FAIL rst_no_resp%0d: got %b want 0000", c, resp_valid); end
    end
    set_op(0, 32'd3, 32'd4);
    req_valid = 4'b0101;
    rst_n = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL rst_first_grant: got %b want 0001", req_ready); end
    tick;
    req_valid = '0;
    tick;
    tick;
    checks++; if (resp_valid !== 4'b0001 || resp_product !== 64'd12) begin errors++; $display("[TB] FAIL rst_reissue: got resp_valid=%b product=%h want 0001/c", resp_valid, resp_product); end
    tick;
  endtask

  task automatic test_drop_after_accept;
    set_op(2, -32'sd100000, 32'd300000);
    req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("[TB] FAIL drop_accept: got %b want 0100", req_ready); end
    tick;
    req_valid = '0;
    set_op(2, 32'h0000_1234, 32'h0000_5678);
    tick;
    tick;
    checks++; if (resp_valid !== 4'b0100) begin errors++; $display("[TB] FAIL drop_resp: got %b want 0100", resp_valid); end
    checks++; if (resp_product !== 64'hFFFF_FFF9_03DC_5400) begin errors++; $display("[TB] FAIL drop_product: got %h want fffffff903dc5400", resp_product); end
    req_valid = 4'b0101;
    #1;
    checks++; if (req_ready !== 4'b0) begin errors++; $display("[TB] FAIL rereq_in_resp: got %b want 0000", req_ready); end
    tick;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL rereq_priority: got %b want 0001", req_ready); end
    req_valid = '0;
    tick;
  endtask

  initial begin
    test_reset;
    test_single;
    test_corners;
    test_round_robin;
    test_backpressure;
    test_reset_in_calc;
    test_drop_after_accept;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
